// File: rtl/dmem_checker.sv
// dmem_checker: run the CPU for a bounded time, then freeze it and compare dmem against expected words
module dmem_checker #(
  parameter int DATA_W = 32,
  parameter int NWORDS = 32,
  parameter int RUN_CYCLES = 1000,
  parameter int EARLY_EXIT = 0,
  localparam int IDX_W = NWORDS > 1 ? $clog2(NWORDS) : 1,
  localparam int CNT_W = $clog2(NWORDS + 1),
  localparam int CYC_W = $clog2(RUN_CYCLES + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              halt_in,
  output logic              cpu_hold,
  output logic [IDX_W-1:0]  chk_idx,
  input  logic [DATA_W-1:0] chk_rdata,
  input  logic [DATA_W-1:0] exp_data,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  fail_count,
  output logic [IDX_W-1:0]  first_fail_idx,
  output logic [DATA_W-1:0] first_fail_got,
  output logic [DATA_W-1:0] first_fail_exp,
  output logic [CYC_W-1:0]  run_cycles
);
  typedef enum logic [1:0] {RUN, CHECK, DONE} state_t;
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(RUN_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NWORDS - 1);
  state_t state, state_nx;
  logic [CYC_W-1:0] cnt;
  logic [IDX_W-1:0] idx;
  logic run_end, chk_end, miss;
  assign chk_idx = idx;
  assign cpu_hold = state != RUN;
  // next-state decode: RUN ends on timeout or (optionally) halt, CHECK ends after the last word
  always_comb begin
    run_end = cnt == CYC_LAST || (EARLY_EXIT != 0 && halt_in);
    chk_end = idx == IDX_LAST;
    miss = chk_rdata != exp_data;
    state_nx = state == RUN ? (run_end ? CHECK : RUN) : state == CHECK ? (chk_end ? DONE : CHECK) : DONE;
  end
  // state register
  always_ff @(posedge clk) state <= reset ? RUN : state_nx;
  // run-cycle count, word walk, mismatch tally and first-failure capture
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
      run_cycles <= '0;
      idx <= '0;
      fail_count <= '0;
      first_fail_idx <= '0;
      first_fail_got <= '0;
      first_fail_exp <= '0;
      done <= 1'b0;
      pass <= 1'b0;
    end else if (state == RUN) begin
      cnt <= cnt + 1'b1;
      run_cycles <= cnt + 1'b1;
    end else if (state == CHECK) begin
      idx <= chk_end ? idx : idx + 1'b1;
      if (miss) begin
        fail_count <= fail_count + 1'b1;
        if (fail_count == '0) begin
          first_fail_idx <= idx;
          first_fail_got <= chk_rdata;
          first_fail_exp <= exp_data;
        end
      end
      if (chk_end) begin
        done <= 1'b1;
        pass <= fail_count == '0 && !miss;
      end
    end
  end
endmodule

// File: tb/tb_dmem_checker.sv
// tb_dmem_checker: directed scenario table plus hand sequences for reset-in-CHECK and the 1-word boundary
module tb_dmem_checker;
  logic clk = 1'b0, reset = 1'b1, halt = 1'b0;
  always #5 clk = ~clk;
  logic [3:0][31:0] rd_v = '0, ex_v = '0;
  logic [31:0] rd2 = '0, ex2 = '0;
  logic h0, h1, h2, d0, d1, d2, p0, p1, p2, i2, fc2, ffi2, rc2;
  logic [1:0] i0, i1, ffi0, ffi1;
  logic [2:0] fc0, fc1;
  logic [3:0] rc0, rc1;
  logic [31:0] fg0, fe0, fg1, fe1, fg2, fe2;
  int checks = 0, failures = 0;
  dmem_checker #(.DATA_W(32), .NWORDS(4), .RUN_CYCLES(10), .EARLY_EXIT(0)) u0 (
    .clk(clk), .reset(reset), .halt_in(halt), .cpu_hold(h0), .chk_idx(i0),
    .chk_rdata(rd_v[i0]), .exp_data(ex_v[i0]), .done(d0), .pass(p0), .fail_count(fc0),
    .first_fail_idx(ffi0), .first_fail_got(fg0), .first_fail_exp(fe0), .run_cycles(rc0));
  dmem_checker #(.DATA_W(32), .NWORDS(4), .RUN_CYCLES(10), .EARLY_EXIT(1)) u1 (
    .clk(clk), .reset(reset), .halt_in(halt), .cpu_hold(h1), .chk_idx(i1),
    .chk_rdata(rd_v[i1]), .exp_data(ex_v[i1]), .done(d1), .pass(p1), .fail_count(fc1),
    .first_fail_idx(ffi1), .first_fail_got(fg1), .first_fail_exp(fe1), .run_cycles(rc1));
  dmem_checker #(.DATA_W(32), .NWORDS(1), .RUN_CYCLES(1), .EARLY_EXIT(0)) u2 (
    .clk(clk), .reset(reset), .halt_in(halt), .cpu_hold(h2), .chk_idx(i2),
    .chk_rdata(rd2), .exp_data(ex2), .done(d2), .pass(p2), .fail_count(fc2),
    .first_fail_idx(ffi2), .first_fail_got(fg2), .first_fail_exp(fe2), .run_cycles(rc2));
  // halt_at: 0 = never, -1 = held high throughout, k = one-cycle pulse sampled at edge k
  typedef struct {
    bit ee;
    int halt_at;
    logic [3:0][31:0] rd, ex;
    int done_at, fc, ffi;
    logic [31:0] got, exp;
    int rc;
    bit pass;
  } vec_t;
  vec_t v[7];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask
  task automatic apply_reset(input int n);
    reset = 1'b1;
    halt = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
      chk("rst_u0_ctl", 32'({d0, p0, h0, fc0, ffi0, i0, rc0}), 0);
      chk("rst_u0_cap", fg0 | fe0, 0);
      chk("rst_u1_ctl", 32'({d1, p1, h1, fc1, ffi1, i1, rc1}), 0);
      chk("rst_u1_cap", fg1 | fe1, 0);
      chk("rst_u2", 32'({d2, p2, h2, fc2, ffi2, i2, rc2}) | fg2 | fe2, 0);
    end
    reset = 1'b0;
  endtask
  task automatic run_body(input string nm, input vec_t t);
    int done_cyc = 0, hold_cyc = 0;
    bit dropped = 0, dn, hd;
    rd_v = t.rd;
    ex_v = t.ex;
    for (int c = 1; c <= 20; c++) begin
      halt = t.halt_at < 0 || t.halt_at == c;
      @(posedge clk);
      #1;
      dn = t.ee ? d1 : d0;
      hd = t.ee ? h1 : h0;
      if (done_cyc != 0 && !dn) dropped = 1;
      if (dn && done_cyc == 0) done_cyc = c;
      if (hd && hold_cyc == 0) hold_cyc = c;
    end
    halt = 1'b0;
    chk({nm, "_done_at"}, done_cyc, t.done_at);
    chk({nm, "_hold_at"}, hold_cyc, t.done_at - 4);
    chk({nm, "_done_hold"}, 32'(dropped), 0);
    chk({nm, "_fc"}, t.ee ? 32'(fc1) : 32'(fc0), t.fc);
    chk({nm, "_ffi"}, t.ee ? 32'(ffi1) : 32'(ffi0), t.ffi);
    chk({nm, "_got"}, t.ee ? fg1 : fg0, t.got);
    chk({nm, "_exp"}, t.ee ? fe1 : fe0, t.exp);
    chk({nm, "_rc"}, t.ee ? 32'(rc1) : 32'(rc0), t.rc);
    chk({nm, "_pass"}, t.ee ? 32'(p1) : 32'(p0), 32'(t.pass));
  endtask
  initial begin
    v[0] = '{0, 0, {32'd9, 32'd6, 32'd3, 32'd0}, {32'd9, 32'd6, 32'd3, 32'd0}, 14, 0, 0, 0, 0, 10, 1};
    v[1] = '{0, 0, {32'd8, 32'd6, 32'd5, 32'd0}, {32'd9, 32'd6, 32'd7, 32'd0}, 14, 2, 1, 5, 7, 10, 0};
    v[2] = '{1, 4, {32'd9, 32'd6, 32'd3, 32'd0}, {32'd9, 32'd6, 32'd3, 32'd0}, 8, 0, 0, 0, 0, 4, 1};
    v[3] = '{0, -1, {32'd9, 32'd6, 32'd3, 32'd0}, {32'd9, 32'd6, 32'd3, 32'd0}, 14, 0, 0, 0, 0, 10, 1};
    v[4] = '{1, 1, {32'd0, 32'd0, 32'd0, 32'h1235}, {32'd0, 32'd0, 32'd0, 32'h1234}, 5, 1, 0, 32'h1235, 32'h1234, 1, 0};
    v[5] = '{1, 0, {32'd9, 32'd6, 32'd3, 32'd0}, {32'd9, 32'd6, 32'd3, 32'd0}, 14, 0, 0, 0, 0, 10, 1};
    v[6] = '{0, 0, {32'd1, 32'd2, 32'd3, 32'd4}, {32'd0, 32'd0, 32'd0, 32'd0}, 14, 4, 0, 4, 0, 10, 0};
    for (int k = 0; k < 7; k++) begin
      apply_reset(2);
      run_body($sformatf("vec%0d", k), v[k]);
    end
    apply_reset(2);
    rd_v = v[1].rd;
    ex_v = v[1].ex;
    repeat (12) @(posedge clk);
    #1;
    chk("mid_fc", 32'(fc0), 1);
    chk("mid_idx", 32'(i0), 2);
    chk("mid_got", fg0, 5);
    apply_reset(1);
    run_body("rerun", v[0]);
    rd2 = 32'h54;
    ex2 = 32'h55;
    apply_reset(2);
    @(posedge clk);
    #1;
    chk("w1_hold", 32'(h2), 1);
    chk("w1_done_early", 32'(d2), 0);
    @(posedge clk);
    #1;
    chk("w1_done", 32'(d2), 1);
    chk("w1_fc", 32'(fc2), 1);
    chk("w1_got", fg2, 32'h54);
    chk("w1_exp", fe2, 32'h55);
    chk("w1_pass", 32'(p2), 0);
    chk("w1_rc", 32'(rc2), 1);
    repeat (3) @(posedge clk);
    #1;
    chk("w1_idx", 32'(i2), 0);
    chk("w1_fc_hold", 32'(fc2), 1);
    chk("w1_done_hold", 32'(d2), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
